// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a start bit, shifts
// out one byte plus odd parity on device clock falls, then checks the device ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 4800,
    parameter int TIMEOUT_CYC = 720000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sym_data,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic       device_clk,
    input  logic       device_dat,
    output logic       device_clk_oe,
    output logic       device_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        START   = 3'd2,
        XFER    = 3'd3,
        ACK     = 3'd4,
        RECOVER = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t        state_r;
    logic [7:0]    byte_r;
    logic [CW-1:0] cnt_r;
    logic [3:0]    edge_cnt_r;
    logic          ack_r;
    logic [1:0]    clk_sync_r;
    logic [1:0]    dat_sync_r;
    logic          clk_prev_r;
    logic          sym_ready_r;
    logic          clk_oe_r;
    logic          dat_oe_r;
    logic          busy_r;
    logic          tx_done_r;
    logic          tx_err_r;

    logic clk_s;
    logic dat_s;
    logic fall_s;
    logic in_frame_s;
    logic timeout_s;

    assign clk_s      = clk_sync_r[1];
    assign dat_s      = dat_sync_r[1];
    assign fall_s     = clk_prev_r & ~clk_s;
    assign in_frame_s = (state_r == START) || (state_r == XFER) ||
                        (state_r == ACK)   || (state_r == RECOVER);
    assign timeout_s  = (cnt_r == CW'(TIMEOUT_CYC - 1));

    assign sym_ready     = sym_ready_r;
    assign device_clk_oe = clk_oe_r;
    assign device_dat_oe = dat_oe_r;
    assign busy          = busy_r;
    assign tx_done       = tx_done_r;
    assign tx_err        = tx_err_r;

    // Two-flop synchronizers for the raw bus lines plus the previous clock sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
            clk_prev_r <= 1'b1;
        end else begin
            clk_sync_r <= {clk_sync_r[0], device_clk};
            dat_sync_r <= {dat_sync_r[0], device_dat};
            clk_prev_r <= clk_s;
        end
    end

    // Transfer sequencer with registered line drivers and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            byte_r      <= 8'h00;
            cnt_r       <= {CW{1'b0}};
            edge_cnt_r  <= 4'd0;
            ack_r       <= 1'b0;
            sym_ready_r <= 1'b0;
            clk_oe_r    <= 1'b0;
            dat_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            tx_done_r   <= 1'b0;
            tx_err_r    <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            tx_err_r  <= 1'b0;
            if (in_frame_s && timeout_s) begin
                state_r     <= IDLE;
                clk_oe_r    <= 1'b0;
                dat_oe_r    <= 1'b0;
                busy_r      <= 1'b0;
                sym_ready_r <= 1'b1;
                tx_err_r    <= 1'b1;
                cnt_r       <= {CW{1'b0}};
            end else begin
                if (in_frame_s) begin
                    cnt_r <= fall_s ? {CW{1'b0}} : cnt_r + CW'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
                case (state_r)
                    IDLE: begin
                        if (sym_valid && sym_ready_r) begin
                            byte_r      <= sym_data;
                            state_r     <= INHIBIT;
                            clk_oe_r    <= 1'b1;
                            dat_oe_r    <= 1'b0;
                            busy_r      <= 1'b1;
                            sym_ready_r <= 1'b0;
                            cnt_r       <= {CW{1'b0}};
                        end else begin
                            sym_ready_r <= 1'b1;
                        end
                    end
                    // The extra cycle after INHIBIT_CYC holds clock low with the start bit driven.
                    INHIBIT: begin
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == CW'(INHIBIT_CYC)) begin
                            state_r    <= START;
                            clk_oe_r   <= 1'b0;
                            cnt_r      <= {CW{1'b0}};
                            edge_cnt_r <= 4'd0;
                        end else if (cnt_r == CW'(INHIBIT_CYC - 1)) begin
                            dat_oe_r <= 1'b1;
                        end else begin
                            dat_oe_r <= dat_oe_r;
                        end
                    end
                    START: begin
                        if (fall_s) begin
                            edge_cnt_r <= 4'd1;
                            dat_oe_r   <= ~byte_r[0];
                            state_r    <= XFER;
                        end else begin
                            state_r <= START;
                        end
                    end
                    XFER: begin
                        if (fall_s) begin
                            edge_cnt_r <= edge_cnt_r + 4'd1;
                            if (edge_cnt_r < 4'd8) begin
                                dat_oe_r <= ~byte_r[edge_cnt_r[2:0]];
                            end else if (edge_cnt_r == 4'd8) begin
                                dat_oe_r <= ~odd_parity(byte_r);
                            end else begin
                                dat_oe_r <= 1'b0;
                                state_r  <= ACK;
                            end
                        end else begin
                            state_r <= XFER;
                        end
                    end
                    ACK: begin
                        if (fall_s) begin
                            ack_r      <= ~dat_s;
                            edge_cnt_r <= edge_cnt_r + 4'd1;
                            state_r    <= RECOVER;
                        end else begin
                            state_r <= ACK;
                        end
                    end
                    RECOVER: begin
                        if (clk_s && dat_s) begin
                            state_r     <= IDLE;
                            busy_r      <= 1'b0;
                            sym_ready_r <= 1'b1;
                            tx_done_r   <= ack_r;
                            tx_err_r    <= ~ack_r;
                        end else begin
                            state_r <= RECOVER;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        clk_oe_r <= 1'b0;
                        dat_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
